// File: rtl/bcd_pkg.sv
// Shared constants, state type and digit helper
// for the digit-serial BCD adder.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  function automatic logic bcd_digit_valid(
    input logic [3:0] d
  );
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// Ports: a, b (digits), cin -> sum (digit), cout (decimal carry).
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_t;

  always_comb begin
    w_t  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    cout = w_t > {1'b0, BCD_MAX};
    // low nibble of t+6 equals 4-bit wrap of t[3:0]+6
    sum  = cout ? (w_t[3:0] + BCD_ADJ) : w_t[3:0];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, one digit per clock, LSD first.
// Ports: clk, rst, start, a, b, cin -> busy, done, sum, cout, err.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  state_t              r_state;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic                r_c;
  logic [CW-1:0]       r_cnt;

  logic [3:0] w_ad;
  logic [3:0] w_bd;
  logic [3:0] w_sd;
  logic       w_co;
  logic       w_err;

  // digit mux selected by the counter
  always_comb begin
    w_ad = '0;
    w_bd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_cnt == CW'(i)) begin
        w_ad = r_a[4*i +: BCD_W];
        w_bd = r_b[4*i +: BCD_W];
      end
    end
  end

  always_comb begin
    w_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(a[4*i +: BCD_W]) ||
          !bcd_digit_valid(b[4*i +: BCD_W]))
        w_err = 1'b1;
    end
  end

  bcd_digit_add u_dig (
    .a    (w_ad),
    .b    (w_bd),
    .cin  (r_c),
    .sum  (w_sd),
    .cout (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (r_state)
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_cnt == CW'(i))
              sum[4*i +: BCD_W] <= w_sd;
          end
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DIGITS - 1)) begin
            cout    <= w_co;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= w_err;
            busy    <= 1'b1;
            r_state <= ADD;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized self-checking bench for bcd_serial_adder
// against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int n_chk = 0;
  int n_err = 0;

  bcd_serial_adder #(.DIGITS(DIGITS), .CW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit all_valid(input logic [W-1:0] x);
    for (int i = 0; i < DIGITS; i++)
      if (((x >> (4*i)) & 'hF) > 9) return 0;
    return 1;
  endfunction

  function automatic longint to_dec(input logic [W-1:0] x);
    longint v = 0;
    for (int i = DIGITS - 1; i >= 0; i--)
      v = v * 10 + longint'((x >> (4*i)) & 'hF);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (W'(v % 10) << (4*i));
      v = v / 10;
    end
    return r;
  endfunction

  // Valid operands: plain decimal addition.
  // Invalid: apply the per-digit correction rule.
  task automatic model(input logic [W-1:0] xa, xb,
                       input logic xc,
                       output logic [W-1:0] s,
                       output logic co, e);
    longint lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    e = !(all_valid(xa) && all_valid(xb));
    if (!e) begin
      longint t = to_dec(xa) + to_dec(xb) + longint'(xc);
      co = t >= lim;
      s  = to_bcd(t % lim);
    end else begin
      int c = xc;
      s = '0;
      for (int i = 0; i < DIGITS; i++) begin
        int t = int'((xa >> (4*i)) & 'hF) +
                int'((xb >> (4*i)) & 'hF) + c;
        if (t > 9) begin
          t = (t + 6) & 'hF;
          c = 1;
        end else c = 0;
        s = s | (W'(t) << (4*i));
      end
      co = c[0];
    end
  endtask

  task automatic do_op(input logic [W-1:0] xa, xb,
                       input logic xc,
                       input bit repulse,
                       input bit chain);
    logic [W-1:0] es;
    logic eco, ee;
    logic [W-1:0] mask;
    int n;
    model(xa, xb, xc, es, eco, ee);
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk); #1;
    check("busy_start", busy, 1);
    check("err_start", err, ee);
    check("sum_clear", sum, 0);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      start = repulse && (n == 1 || n == 2);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      n++;
      if (!done && n < DIGITS) begin
        mask = (W'(1) << (4*n)) - W'(1);
        check("partial", sum, es & mask);
        check("busy_mid", busy, 1);
        check("err_mid", err, ee);
      end
    end
    start = 1'b0;
    check("latency", n, DIGITS);
    check("sum", sum, es);
    check("cout", cout, eco);
    check("err", err, ee);
    check("busy_done", busy, 0);
    if (!chain) begin
      @(posedge clk); #1;
      check("done_once", done, 0);
      check("sum_hold", sum, es);
      check("busy_idle", busy, 0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'h1234, 16'h5678, 0, 0, 0);
    do_op(16'h9999, 16'h0001, 0, 0, 0);
    do_op(16'h9999, 16'h9999, 1, 0, 0);
    do_op(16'h0000, 16'h0000, 1, 0, 1);
    do_op(16'h0050, 16'h0050, 0, 0, 0);
    do_op(16'h4321, 16'h1111, 0, 1, 0);
    do_op(16'h12A4, 16'h0000, 0, 0, 0);

    // async reset between edges mid-ADD
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0987, 16'h0013, 1, 0, 0);

    for (int k = 0; k < 24; k++) begin
      ra = '0; rb = '0;
      for (int i = 0; i < DIGITS; i++) begin
        ra = ra | (W'(k % 6 == 5 ? $urandom_range(0, 15)
                                 : $urandom_range(0, 9)) << (4*i));
        rb = rb | (W'($urandom_range(0, 9)) << (4*i));
      end
      do_op(ra, rb, 1'($urandom), k % 7 == 3, k % 4 == 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Digit-serial multi-digit packed-BCD adder: captures two DIGITS-wide BCD operands on start, then adds one decimal digit per clock, least-significant digit first.
- The stage directly upstream of the combinational single-digit BCD adder: sequences digits into it and registers its carry between digits.
- Produces a packed BCD sum, a decimal carry-out and a one-cycle done pulse.
- Used where a wide parallel BCD adder costs too much area.

Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1..16.
- CW, 5, width of the digit counter; must satisfy 2**CW > DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to begin an addition; sampled in IDLE and DONE only.
- a  input  4*DIGITS  operand A, packed BCD; digit i is a[4i+3:4i].
- b  input  4*DIGITS  operand B, packed BCD.
- cin  input  1  carry into digit 0.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when sum/cout are final.
- sum  output  4*DIGITS  packed BCD result.
- cout  output  1  decimal carry out of the most-significant digit.
- err  output  1  high if any captured operand digit was >9.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, digit counter=0, operand and carry registers=0. Reset mid-operation aborts immediately, with no partial-result hold.
- States are IDLE, ADD and DONE.
- IDLE/DONE with start=1 at edge E0:
  - Capture a, b and cin into internal registers.
  - Clear sum to 0 and counter to 0.
  - Set err = OR over all digits of (a_i>9 | b_i>9).
  - Set busy=1 and go to ADD.
  - Operand inputs may change after E0.
- ADD: at each edge Ek (k=1..DIGITS), digit d=k-1 is computed from the registered operand digit and registered carry c:
  - t = a_d + b_d + c, computed 5 bits wide.
  - If t>9: sum_d = (t+6)[3:0] and c=1.
  - Otherwise: sum_d = t[3:0] and c=0.
  - The result is written into sum[4d+3:4d] and the counter increments.
  - At E_DIGITS: cout=c, busy=0, done=1, go to DONE.
- DONE lasts exactly one cycle (done=1), then returns to IDLE with done=0. A start sampled in DONE is accepted exactly as in IDLE.
- Latency: done is high in the cycle following edge E_DIGITS, i.e. DIGITS+1 edges after the start edge E0. Throughput is one addition per DIGITS+1 cycles.
- start while busy=1 is ignored; no queuing.
- sum, cout and err hold their values from done until the next accepted start. sum digits not yet processed read 0 while busy.
- Invalid digits (>9) are not blocked: the same correction rule is applied and err flags the result as meaningless.
- DIGITS=1: ADD lasts one edge.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W=4 and BCD_MAX=9, with BCD_ADJ=6.
  - An enum type for the state (IDLE, ADD, DONE).
  - A function bcd_digit_valid.
- One natural sub-module: bcd_digit_add (combinational; inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout), instantiated once and fed by a digit mux driven by the counter.

Test Plan:
1. DIGITS=4, a=0x1234, b=0x5678, cin=0, start for 1 cycle -> busy for 4 cycles, done on cycle 5, sum=0x6912, cout=0, err=0.
2. a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
3. a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0; then start asserted during the done cycle with a=0x0050, b=0x0050 -> accepted, sum=0x0100 five cycles later.
4. start re-pulsed at cycles 2 and 3 of an operation with different operands -> ignored; first result unchanged and done pulses exactly once.
5. a=0x12A4, b=0x0000 -> err=1 from the cycle after start, held through done; sum follows the correction rule (0x1304).
6. rst asserted asynchronously mid-ADD (between edges) -> busy, done, sum, cout and err drop to 0 immediately; after release a new start completes normally.
